mealy_seq_det: RTL and testbench

Parametrised Mealy sequence detector; next generation of the fixed 1011 detector. Bit pattern and length are runtime-loadable up to `MAX_LEN`, with selectable overlapping or non-overlapping detection, gated input sampling and a saturating match counter. Sits on a serial bit stream one bit per clock; `z` feeds downstream control logic combinationally in the same cycle as the completing bit.

---
 rtl/seq_det_pkg.sv | 12 +
 rtl/sat_counter.sv | 20 ++
 rtl/mealy_seq_det.sv | 92 +++++++++
 tb/tb_mealy_seq_det.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared length bounds and field-width helper for sequence detectors
package seq_det_pkg;

  localparam int MIN_PAT_LEN = 2;
  localparam int MAX_PAT_LEN = 32;

  // Width of a field that must hold every value 0..max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that clears on request and sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/mealy_seq_det.sv
// rtl/mealy_seq_det.sv - runtime-loadable Mealy bit-pattern detector with match counter
module mealy_seq_det
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'('b1011),
  parameter int                 DEF_LEN = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         x,
  input  logic                         pat_load,
  input  logic [MAX_LEN-1:0]           pat,
  input  logic [len_w(MAX_LEN)-1:0]    pat_len,
  input  logic                         overlap,
  output logic                         z,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cfg_err
);

  localparam int            LW       = len_w(MAX_LEN);
  localparam logic [LW-1:0] FILL_MAX = LW'(MAX_LEN - 1);

  logic [MAX_LEN-1:0] cur_pat;
  logic [LW-1:0]      cur_len;
  logic [MAX_LEN-2:0] hist;
  logic [LW-1:0]      fill;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic               hit;
  logic               fill_ok;
  logic               load_ok;

  // Newest bit sits at window[0], lining up with pat[0] (the last pattern bit).
  assign window = {hist, x};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < cur_len);
    end
  end

  assign hit     = ((window ^ cur_pat) & mask) == '0;
  assign fill_ok = fill >= (cur_len - LW'(1));
  assign load_ok = (pat_len >= LW'(MIN_PAT_LEN)) && (pat_len <= LW'(MAX_LEN));
  assign z       = reset & en & ~pat_load & fill_ok & hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_pat <= DEF_PAT;
      cur_len <= LW'(DEF_LEN);
      hist    <= '0;
      fill    <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (pat_load) begin
        if (load_ok) begin
          cur_pat <= pat;
          cur_len <= pat_len;
          hist    <= '0;
          fill    <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (en) begin
        hist <= window[MAX_LEN-2:0];
        // Non-overlapping mode forgets the matched bits by emptying the depth count.
        if (z && !overlap) begin
          fill <= '0;
        end else if (fill != FILL_MAX) begin
          fill <= fill + LW'(1);
        end
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (pat_load & load_ok),
    .inc   (z),
    .q     (match_cnt)
  );

endmodule

// File: tb/tb_mealy_seq_det.sv
// tb/tb_mealy_seq_det.sv - scoreboard bench for mealy_seq_det, default and 2-bit counter instances
module tb_mealy_seq_det;

  localparam int MAX_LEN = 8;
  localparam int LW      = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic               x;
  logic               pat_load;
  logic [MAX_LEN-1:0] pat;
  logic [LW-1:0]      pat_len;
  logic               overlap;
  logic               z, z2;
  logic [7:0]         cnt;
  logic [1:0]         cnt2;
  logic               cfg_err, cfg_err2;

  always #5 clk = ~clk;

  mealy_seq_det u_dut (
    .clk(clk), .reset(reset), .en(en), .x(x), .pat_load(pat_load), .pat(pat),
    .pat_len(pat_len), .overlap(overlap), .z(z), .match_cnt(cnt), .cfg_err(cfg_err)
  );

  mealy_seq_det #(.CNT_W(2)) u_small (
    .clk(clk), .reset(reset), .en(en), .x(x), .pat_load(pat_load), .pat(pat),
    .pat_len(pat_len), .overlap(overlap), .z(z2), .match_cnt(cnt2), .cfg_err(cfg_err2)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic               sb_q[$];
  bit                 mq[$];
  logic [MAX_LEN-1:0] mpat;
  int                 mlen;
  int                 mcnt8;
  int                 mcnt2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mpat  = 8'b0000_1011;
    mlen  = 4;
    mq.delete();
    mcnt8 = 0;
    mcnt2 = 0;
  endtask

  // mq holds received bits oldest-first; the last entry pairs with mpat[1].
  function automatic logic model_z(input logic b);
    if (mq.size() < mlen - 1) return 1'b0;
    if (b != mpat[0]) return 1'b0;
    for (int i = 1; i < mlen; i++) begin
      if (mq[mq.size() - i] != mpat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input logic e, input logic b);
    logic zz;
    logic want;
    @(posedge clk);
    #1;
    reset    = 1'b1;
    pat_load = 1'b0;
    en       = e;
    x        = b;
    zz = e ? model_z(b) : 1'b0;
    if (zz) begin
      if (mcnt8 < 255) mcnt8++;
      if (mcnt2 < 3) mcnt2++;
    end
    if (e) begin
      if (zz && !overlap) begin
        mq.delete();
      end else begin
        mq.push_back(b);
        if (mq.size() > MAX_LEN - 1) void'(mq.pop_front());
      end
    end
    sb_q.push_back(zz);
    @(negedge clk);
    want = sb_q.pop_front();
    check("z", z, want);
    check("z_small", z2, want);
  endtask

  task automatic stream(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, v[i]);
  endtask

  task automatic idle();
    logic b;
    b = 1'($urandom_range(0, 1));
    step(1'b0, b);
  endtask

  task automatic check_cnt(input int want8, input int want2);
    step(1'b0, 1'b0);
    check("match_cnt", cnt, want8);
    check("match_cnt_small", cnt2, want2);
  endtask

  task automatic do_reset(input logic b);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    pat_load = 1'b0;
    en       = 1'b1;
    x        = b;
    sb_q.push_back(1'b0);
    @(negedge clk);
    check("z_in_reset", z, sb_q.pop_front());
    model_reset();
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ok);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    pat_load = 1'b1;
    pat      = p;
    pat_len  = l;
    en       = 1'b1;
    x        = 1'b1;
    sb_q.push_back(1'b0);
    @(negedge clk);
    check("z_on_load", z, sb_q.pop_front());
    if (ok) begin
      mpat  = p;
      mlen  = int'(l);
      mq.delete();
      mcnt8 = 0;
      mcnt2 = 0;
    end
    step(1'b0, 1'b0);
    check("cfg_err_pulse", cfg_err, {31'd0, !ok});
    check("cnt_after_load", cnt, mcnt8);
    step(1'b0, 1'b0);
    check("cfg_err_end", cfg_err, 0);
  endtask

  initial begin
    reset    = 1'b0;
    en       = 1'b0;
    x        = 1'b0;
    pat_load = 1'b0;
    pat      = '0;
    pat_len  = '0;
    overlap  = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_z", z, 0);
    check("reset_cnt", cnt, 0);
    check("reset_cnt_small", cnt2, 0);
    check("reset_cfg_err", cfg_err, 0);

    overlap = 1'b1;
    stream(32'b1011011, 7);
    check_cnt(2, 2);

    do_reset(1'b1);
    overlap = 1'b0;
    stream(32'b1011011, 7);
    check_cnt(1, 1);

    overlap = 1'b1;
    load(8'b0011_0011, 4'd6, 1'b1);
    stream(32'b1100110011, 10);
    check_cnt(2, 2);

    do_reset(1'b0);
    load(8'hFF, 4'd1, 1'b0);
    stream(32'b1011, 4);
    check_cnt(1, 1);
    load(8'hFF, 4'd9, 1'b0);
    stream(32'b011, 3);
    check_cnt(2, 2);

    do_reset(1'b1);
    stream(32'b10, 2);
    repeat (3) idle();
    stream(32'b11, 2);
    check_cnt(1, 1);

    do_reset(1'b0);
    stream(32'b1011011011011011, 16);
    check_cnt(5, 3);

    do_reset(1'b0);
    stream(32'b101, 3);
    do_reset(1'b1);
    step(1'b1, 1'b1);
    check_cnt(0, 0);
    check("cfg_err_final", cfg_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
